// File: rtl/round_robin_dist.sv
// Round-robin distributor: scatters one valid/ready stream over WIDTH
// consumers in cyclic order, skipping consumers whose enable bit is low.
// The output side is a single registered word with pass-through accept.
module round_robin_dist #(
  parameter int WIDTH   = 8,
  parameter int DATA_W  = 32,
  parameter int WIDTH_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  dst_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [WIDTH-1:0]  m_valid,
  input  logic [WIDTH-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [WIDTH_W-1:0] m_bin
);

  // Architectural state
  logic [WIDTH_W-1:0] r_ptr;
  logic               r_buf_valid;
  logic [WIDTH-1:0]   r_buf_dst;
  logic [WIDTH_W-1:0] r_buf_bin;
  logic [DATA_W-1:0]  r_buf_data;

  // Combinational decisions
  logic [WIDTH_W-1:0] w_pick_hi;
  logic [WIDTH_W-1:0] w_pick_lo;
  logic               w_found_hi;
  logic               w_found_lo;
  logic [WIDTH_W-1:0] w_pick;
  logic [WIDTH_W-1:0] w_ptr_nxt;
  logic               w_any_en;
  logic               w_drain;
  logic               w_accept;

  // Lowest enabled index at or above the pointer, else lowest enabled overall
  always_comb begin
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dst_en[i]) begin
        if (!w_found_lo) begin
          w_pick_lo  = WIDTH_W'(i);
          w_found_lo = 1'b1;
        end else begin
          w_found_lo = w_found_lo;
        end
        if (!w_found_hi && (WIDTH_W'(i) >= r_ptr)) begin
          w_pick_hi  = WIDTH_W'(i);
          w_found_hi = 1'b1;
        end else begin
          w_found_hi = w_found_hi;
        end
      end else begin
        w_found_lo = w_found_lo;
      end
    end
    if (w_found_hi) begin
      w_pick = w_pick_hi;
    end else begin
      w_pick = w_pick_lo;
    end
  end

  // Handshake terms: only the addressed consumer's ready can drain the buffer
  always_comb begin
    w_any_en  = |dst_en;
    w_drain   = r_buf_valid & (|(r_buf_dst & m_ready));
    s_ready   = ~rst & w_any_en & (~r_buf_valid | w_drain);
    w_accept  = s_valid & s_ready;
    if (w_pick == WIDTH_W'(WIDTH - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_pick + WIDTH_W'(1);
    end
  end

  // Output buffer and rotation pointer; pointer only advances on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_buf_valid <= 1'b0;
      r_buf_dst   <= '0;
      r_buf_bin   <= '0;
      r_buf_data  <= '0;
    end else if (w_accept) begin
      r_ptr       <= w_ptr_nxt;
      r_buf_valid <= 1'b1;
      r_buf_dst   <= WIDTH'(1) << w_pick;
      r_buf_bin   <= w_pick;
      r_buf_data  <= s_data;
    end else if (w_drain) begin
      r_buf_valid <= 1'b0;
    end else begin
      r_buf_valid <= r_buf_valid;
    end
  end

  // Outputs come straight from the buffer registers, never from m_ready
  always_comb begin
    m_valid = r_buf_valid ? r_buf_dst : '0;
    m_data  = r_buf_data;
    m_bin   = r_buf_bin;
  end

endmodule

// File: tb/tb_round_robin_dist.sv
// Scoreboard bench for round_robin_dist (WIDTH=4). The driver pushes the
// hand-computed destination of each accepted word; a monitor pops and
// compares whenever a word leaves the output buffer.
module tb_round_robin_dist;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dst_en;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [31:0] m_data;
  logic [1:0]  m_bin;

  typedef struct packed {
    logic [3:0]  dst;
    logic [1:0]  bin;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   w;

  round_robin_dist #(.WIDTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .dst_en(dst_en), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_bin(m_bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word until accepted; record its expected destination on accept
  task automatic send(input logic [31:0] d, input int bin, output int waited);
    bit   acc;
    exp_t e;
    acc     = 1'b0;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && waited < 50) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        e.dst  = 4'b0001 << bin;
        e.bin  = 2'(bin);
        e.data = d;
        exp_q.push_back(e);
        acc = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: every completed output transfer must match the scoreboard head
  always @(negedge clk) begin
    if (rst === 1'b0 && (m_valid & m_ready) != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected", {28'h0, m_valid}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_dst",  {28'h0, m_valid}, {28'h0, mon_e.dst});
        chk("mon_bin",  {30'h0, m_bin},   {30'h0, mon_e.bin});
        chk("mon_data", m_data,           mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    dst_en  = 4'b1111;
    s_valid = 1'b0;
    s_data  = 32'h0;
    m_ready = 4'b1111;
    tick(); tick();
    @(negedge clk);
    chk("rst_m_valid", {28'h0, m_valid}, 32'h0);
    chk("rst_m_data",  m_data,           32'h0);
    chk("rst_m_bin",   {30'h0, m_bin},   32'h0);
    chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: all enabled, continuous stream, 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) begin
      send(32'hA0 + 32'(i), i % 4, w);
      chk("t1_wait", w, 32'd0);
      if (i == 0) begin
        chk("t1_latency_valid", {28'h0, m_valid}, 32'h1);
        chk("t1_latency_data",  m_data,           32'hA0);
      end
    end
    idle(2);
    chk("t1_idle_valid", {28'h0, m_valid}, 32'h0);

    // 2: only consumers 1 and 3 enabled
    dst_en = 4'b1010;
    send(32'hB0, 1, w);
    send(32'hB1, 3, w);
    send(32'hB2, 1, w);
    send(32'hB3, 3, w);
    idle(2);

    // 3: backpressure on consumer 2, then drain and accept in the same cycle
    dst_en = 4'b1111;
    send(32'hC0, 0, w);
    send(32'hC1, 1, w);
    send(32'hC2, 2, w);
    m_ready = 4'b1011;
    s_valid = 1'b1;
    s_data  = 32'hC3;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", {28'h0, m_valid}, 32'h4);
      chk("t3_hold_data",  m_data,           32'hC2);
      chk("t3_hold_ready", {31'h0, s_ready}, 32'h0);
      @(posedge clk); #1;
    end
    m_ready = 4'b1111;
    send(32'hC3, 3, w);
    chk("t3_pass_through", w, 32'd0);
    idle(2);

    // 4: nothing enabled stalls upstream, pointer must not move
    dst_en  = 4'b0000;
    s_valid = 1'b1;
    s_data  = 32'hD0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_ready", {31'h0, s_ready}, 32'h0);
      chk("t4_stall_valid", {28'h0, m_valid}, 32'h0);
      @(posedge clk); #1;
    end
    dst_en = 4'b0100;
    send(32'hD0, 2, w);
    chk("t4_wait", w, 32'd0);

    // 5: pointer at 3 wraps to 0, then 1, then wraps to 0 again;
    //    D0 stays aimed at consumer 2 despite the enable change
    dst_en = 4'b0011;
    send(32'hE0, 0, w);
    send(32'hE1, 1, w);
    send(32'hE2, 0, w);
    idle(2);

    // 6: reset discards a buffered word for consumer 1
    dst_en = 4'b1111;
    send(32'hF0, 1, w);
    m_ready = 4'b0000;
    tick();
    @(negedge clk);
    chk("t6_held_valid", {28'h0, m_valid}, 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", {31'h0, s_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    chk("t6_after_valid", {28'h0, m_valid}, 32'h0);
    chk("t6_after_data",  m_data,           32'h0);
    chk("t6_after_bin",   {30'h0, m_bin},   32'h0);
    @(posedge clk); #1;
    m_ready = 4'b1111;
    send(32'h60, 0, w);
    chk("t6_first_wait", w, 32'd0);
    idle(3);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
